// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divisors and buffer sizing.
package uart_pkg;

    localparam int unsigned UART_CLK_HZ = 100_000_000;
    localparam int unsigned RX_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        RxIdle  = 2'd0,
        RxStart = 2'd1,
        RxData  = 2'd2,
        RxStop  = 2'd3
    } rx_state_e;

    // Clocks per bit for each baud_rx_sel code, rounded down.
    localparam int unsigned BAUD_CNT_9600   = UART_CLK_HZ / 9600;
    localparam int unsigned BAUD_CNT_19200  = UART_CLK_HZ / 19200;
    localparam int unsigned BAUD_CNT_38400  = UART_CLK_HZ / 38400;
    localparam int unsigned BAUD_CNT_57600  = UART_CLK_HZ / 57600;
    localparam int unsigned BAUD_CNT_115200 = UART_CLK_HZ / 115200;
    localparam int unsigned BAUD_CNT_230400 = UART_CLK_HZ / 230400;
    localparam int unsigned BAUD_CNT_460800 = UART_CLK_HZ / 460800;
    localparam int unsigned BAUD_CNT_921600 = UART_CLK_HZ / 921600;

    function automatic int unsigned baud_cnt(input logic [2:0] sel);
        int unsigned cnt;
        unique case (sel)
            3'd0:    cnt = BAUD_CNT_9600;
            3'd1:    cnt = BAUD_CNT_19200;
            3'd2:    cnt = BAUD_CNT_38400;
            3'd3:    cnt = BAUD_CNT_57600;
            3'd4:    cnt = BAUD_CNT_115200;
            3'd5:    cnt = BAUD_CNT_230400;
            3'd6:    cnt = BAUD_CNT_460800;
            default: cnt = BAUD_CNT_921600;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x 8 byte store with one synchronous write port and an asynchronous read port.
module uart_fifo_ram #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    // Contents are undefined after reset; occupancy is tracked by the owner.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: FWFT byte FIFO with fill level, threshold, overrun and idle-timeout status.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH     = RX_FIFO_DEPTH,
    parameter int unsigned ADDR_W    = $clog2(DEPTH),
    parameter int unsigned TO_CYCLES = 34720
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              uart_en,
    input  logic              flush,
    input  logic              rec_valid,
    input  logic [7:0]        rec_dat,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    input  logic [ADDR_W:0]   rx_thresh,
    output logic              thresh_irq,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              rx_timeout
);

    localparam int unsigned IDLE_W = $clog2(TO_CYCLES + 1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TO_CYCLES);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovr_q, ovr_d;
    logic [IDLE_W-1:0] idle_q, idle_d;

    logic       do_push;
    logic       do_pop;
    logic       ovr_set;
    logic [7:0] ram_rdata;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte then.
    assign do_pop  = rd_en & ~empty & ~flush;
    assign do_push = rec_valid & uart_en & ~flush & (~full | do_pop);
    assign ovr_set = rec_valid & uart_en & full & ~do_pop & ~flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_comb begin
        ovr_d = ovr_q;
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    // Idle time only accumulates while bytes sit untouched in the buffer.
    always_comb begin
        idle_d = idle_q;
        if (flush || do_push || do_pop || empty) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            idle_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            idle_q  <= idle_d;
        end
    end

    uart_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .we    (do_push),
        .waddr (wptr_q),
        .wdata (rec_dat),
        .raddr (rptr_q),
        .rdata (ram_rdata)
    );

    assign rd_data    = empty ? 8'h00 : ram_rdata;
    assign count      = count_q;
    assign overrun    = ovr_q;
    assign thresh_irq = (rx_thresh != '0) && (count_q >= rx_thresh);
    assign rx_timeout = (idle_q == IDLE_MAX) && !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic vs a queue model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int TO    = 100;

    logic       clock = 1'b0;
    logic       resetn;
    logic       uart_en, flush, rec_valid, rd_en, ovr_clr;
    logic [7:0] rec_dat;
    logic [4:0] rx_thresh;
    logic [7:0] rd_data;
    logic       empty, full, thresh_irq, overrun, rx_timeout;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;

    // Reference model: byte queue, sticky overrun, and cycle stamp of the last idle-clearing event.
    logic [7:0] mq[$];
    bit         m_ovr;
    int         cyc;
    int         last_evt;

    uart_rx_fifo #(
        .DEPTH     (DEPTH),
        .ADDR_W    (4),
        .TO_CYCLES (TO)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .uart_en    (uart_en),
        .flush      (flush),
        .rec_valid  (rec_valid),
        .rec_dat    (rec_dat),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .rx_thresh  (rx_thresh),
        .thresh_irq (thresh_irq),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
        .rx_timeout (rx_timeout)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    task automatic model_reset();
        mq.delete();
        m_ovr    = 1'b0;
        last_evt = cyc;
    endtask

    // Advance one clock; the model consumes the inputs held stable across the rising edge.
    task automatic tick();
        bit was_empty, m_full, m_pop, m_push, m_set;
        @(posedge clock);
        cyc++;
        if (!resetn) begin
            model_reset();
        end else begin
            was_empty = (mq.size() == 0);
            m_full    = (mq.size() == DEPTH);
            m_pop     = rd_en && !was_empty && !flush;
            m_push    = rec_valid && uart_en && !flush && (!m_full || m_pop);
            m_set     = rec_valid && uart_en && m_full && !m_pop && !flush;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) mq.push_back(rec_dat);
            end
            if (m_set) m_ovr = 1'b1;
            else if (ovr_clr) m_ovr = 1'b0;
            if (flush || m_push || m_pop || was_empty) last_evt = cyc;
        end
        @(negedge clock);
    endtask

    task automatic clr_in();
        rec_valid = 1'b0;
        rd_en     = 1'b0;
        flush     = 1'b0;
        ovr_clr   = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        rec_valid = 1'b1;
        rec_dat   = d;
        tick();
        rec_valid = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        uart_en   = 1'b1;
        rec_dat   = 8'h00;
        rx_thresh = 5'd0;
        clr_in();
        cyc = 0;
        model_reset();
        tick();
        tick();
        resetn = 1'b1;
        tick();
        checks++; if (empty !== 1'b1) begin errors++;
            $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++;
            $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (count !== 5'd0) begin errors++;
            $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (rd_data !== 8'h00) begin errors++;
            $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        checks++; if ({thresh_irq, overrun, rx_timeout} !== 3'b000) begin errors++;
            $display("FAIL reset_flags: got %b want 000", {thresh_irq, overrun, rx_timeout}); end
    endtask

    task automatic test_single();
        push(8'hA5);
        checks++; if (empty !== 1'b0 || count !== 5'd1 || rd_data !== 8'hA5) begin errors++;
            $display("FAIL single_push: got empty=%b count=%0d data=%h want 0 1 a5",
                     empty, count, rd_data); end
        pop();
        checks++; if (empty !== 1'b1 || count !== 5'd0 || rd_data !== 8'h00) begin errors++;
            $display("FAIL single_pop: got empty=%b count=%0d data=%h want 1 0 00",
                     empty, count, rd_data); end
        pop();
        checks++; if (empty !== 1'b1 || count !== 5'd0) begin errors++;
            $display("FAIL pop_when_empty: got empty=%b count=%0d want 1 0", empty, count); end
    endtask

    task automatic test_full_overrun();
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        checks++; if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b0) begin errors++;
            $display("FAIL fill16: got full=%b count=%0d ovr=%b want 1 16 0",
                     full, count, overrun); end
        push(8'hFF);
        checks++; if (overrun !== 1'b1 || count !== 5'd16) begin errors++;
            $display("FAIL overrun_set: got ovr=%b count=%0d want 1 16", overrun, count); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (rd_data !== 8'(i)) begin errors++;
                $display("FAIL drain_order[%0d]: got %h want %h", i, rd_data, 8'(i)); end
            pop();
        end
        checks++; if (empty !== 1'b1 || overrun !== 1'b1) begin errors++;
            $display("FAIL drained_sticky: got empty=%b ovr=%b want 1 1", empty, overrun); end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++;
            $display("FAIL ovr_clr: got %b want 0", overrun); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] d;
        logic [7:0] last;
        for (int i = 0; i < DEPTH; i++) push(8'($urandom));
        for (int k = 0; k < 20; k++) begin
            d = (k == 19) ? 8'h55 : 8'($urandom);
            checks++; if (rd_data !== mq[0]) begin errors++;
                $display("FAIL pushpop_head[%0d]: got %h want %h", k, rd_data, mq[0]); end
            rec_valid = 1'b1;
            rec_dat   = d;
            rd_en     = 1'b1;
            tick();
            clr_in();
            checks++; if (count !== 5'd16 || overrun !== 1'b0) begin errors++;
                $display("FAIL pushpop_full[%0d]: got count=%0d ovr=%b want 16 0",
                         k, count, overrun); end
        end
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (rd_data !== mq[0]) begin errors++;
                $display("FAIL wrap_drain[%0d]: got %h want %h", i, rd_data, mq[0]); end
            last = rd_data;
            pop();
        end
        checks++; if (last !== 8'h55) begin errors++;
            $display("FAIL last_popped: got %h want 55", last); end
    endtask

    task automatic test_thresh();
        rx_thresh = 5'd4;
        for (int i = 0; i < 3; i++) begin
            push(8'($urandom));
            checks++; if (thresh_irq !== 1'b0) begin errors++;
                $display("FAIL thresh_below[%0d]: got %b want 0", i, thresh_irq); end
        end
        push(8'h44);
        checks++; if (thresh_irq !== 1'b1) begin errors++;
            $display("FAIL thresh_reach: got %b want 1", thresh_irq); end
        pop();
        checks++; if (thresh_irq !== 1'b0) begin errors++;
            $display("FAIL thresh_pop: got %b want 0", thresh_irq); end
        while (mq.size() < DEPTH) push(8'($urandom));
        rx_thresh = 5'd16;
        #1;
        checks++; if (thresh_irq !== 1'b1) begin errors++;
            $display("FAIL thresh_16: got %b want 1", thresh_irq); end
        rx_thresh = 5'd0;
        #1;
        checks++; if (thresh_irq !== 1'b0) begin errors++;
            $display("FAIL thresh_disabled: got %b want 0", thresh_irq); end
        do_flush();
    endtask

    task automatic test_timeout();
        push(8'h77);
        repeat (TO - 1) tick();
        checks++; if (rx_timeout !== 1'b0) begin errors++;
            $display("FAIL timeout_early: got %b want 0", rx_timeout); end
        tick();
        checks++; if (rx_timeout !== 1'b1) begin errors++;
            $display("FAIL timeout_exact: got %b want 1", rx_timeout); end
        repeat (5) tick();
        checks++; if (rx_timeout !== 1'b1) begin errors++;
            $display("FAIL timeout_hold: got %b want 1", rx_timeout); end
        pop();
        checks++; if (rx_timeout !== 1'b0 || empty !== 1'b1) begin errors++;
            $display("FAIL timeout_pop: got to=%b empty=%b want 0 1", rx_timeout, empty); end
        push(8'h11);
        repeat (TO) tick();
        push(8'h22);
        checks++; if (rx_timeout !== 1'b0 || count !== 5'd2) begin errors++;
            $display("FAIL timeout_push: got to=%b count=%0d want 0 2", rx_timeout, count); end
        do_flush();
    endtask

    task automatic test_uart_disable();
        for (int i = 0; i < DEPTH; i++) push(8'(8'h80 + i));
        uart_en = 1'b0;
        repeat (3) push(8'hEE);
        checks++; if (count !== 5'd16 || overrun !== 1'b0) begin errors++;
            $display("FAIL disabled_ignore: got count=%0d ovr=%b want 16 0", count, overrun); end
        pop();
        checks++; if (count !== 5'd15 || rd_data !== 8'h81) begin errors++;
            $display("FAIL disabled_pop: got count=%0d data=%h want 15 81", count, rd_data); end
        uart_en = 1'b1;
        do_flush();
    endtask

    task automatic test_flush();
        for (int i = 0; i <= DEPTH; i++) push(8'($urandom));
        do_flush();
        checks++; if (count !== 5'd0 || empty !== 1'b1 || overrun !== 1'b1) begin errors++;
            $display("FAIL flush_keeps_ovr: got count=%0d empty=%b ovr=%b want 0 1 1",
                     count, empty, overrun); end
        for (int i = 0; i < 5; i++) push(8'($urandom));
        rec_valid = 1'b1;
        rec_dat   = 8'h99;
        rd_en     = 1'b1;
        flush     = 1'b1;
        ovr_clr   = 1'b1;
        tick();
        clr_in();
        checks++; if (count !== 5'd0 || empty !== 1'b1 || overrun !== 1'b0 ||
                      rd_data !== 8'h00) begin errors++;
            $display("FAIL flush_push_clr: got count=%0d empty=%b ovr=%b data=%h want 0 1 0 00",
                     count, empty, overrun, rd_data); end
    endtask

    task automatic test_set_wins();
        for (int i = 0; i < DEPTH; i++) push(8'($urandom));
        rec_valid = 1'b1;
        ovr_clr   = 1'b1;
        tick();
        clr_in();
        checks++; if (overrun !== 1'b1) begin errors++;
            $display("FAIL ovr_set_wins: got %b want 1", overrun); end
    endtask

    task automatic test_midstream_reset();
        for (int i = 0; i < 3; i++) push(8'($urandom));
        rec_valid = 1'b1;
        rec_dat   = 8'hC3;
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        checks++; if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || overrun !== 1'b0 ||
                      rd_data !== 8'h00 || rx_timeout !== 1'b0) begin errors++;
            $display("FAIL async_reset: got empty=%b full=%b count=%0d ovr=%b data=%h to=%b",
                     empty, full, count, overrun, rd_data, rx_timeout); end
        rec_valid = 1'b0;
        @(negedge clock);
        tick();
        rec_valid = 1'b1;
        rec_dat   = 8'h3C;
        resetn    = 1'b1;
        tick();
        rec_valid = 1'b0;
        checks++; if (count !== 5'd1 || rd_data !== 8'h3C) begin errors++;
            $display("FAIL post_reset_push: got count=%0d data=%h want 1 3c", count, rd_data); end
    endtask

    task automatic test_random();
        bit         quiet;
        logic [7:0] e_data;
        bit         e_to;
        for (int n = 0; n < 900; n++) begin
            quiet     = ((n / 150) % 2) == 1;
            rec_valid = quiet ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 9) < 6);
            rd_en     = quiet ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 9) < 3);
            flush     = quiet ? 1'b0 : ($urandom_range(0, 59) == 0);
            uart_en   = $urandom_range(0, 9) != 0;
            ovr_clr   = $urandom_range(0, 7) == 0;
            rec_dat   = 8'($urandom);
            if (n % 50 == 0) rx_thresh = 5'($urandom_range(0, 16));
            tick();
            e_data = (mq.size() > 0) ? mq[0] : 8'h00;
            e_to   = (mq.size() > 0) && ((cyc - last_evt) >= TO);
            checks++; if (count !== 5'(mq.size())) begin errors++;
                $display("FAIL rnd_count@%0d: got %0d want %0d", n, count, mq.size()); end
            checks++; if (rd_data !== e_data) begin errors++;
                $display("FAIL rnd_data@%0d: got %h want %h", n, rd_data, e_data); end
            checks++; if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
                errors++;
                $display("FAIL rnd_flags@%0d: got empty=%b full=%b size %0d",
                         n, empty, full, mq.size()); end
            checks++; if (overrun !== m_ovr) begin errors++;
                $display("FAIL rnd_ovr@%0d: got %b want %b", n, overrun, m_ovr); end
            checks++; if (thresh_irq !== (rx_thresh != 0 && mq.size() >= int'(rx_thresh))) begin
                errors++;
                $display("FAIL rnd_thresh@%0d: got %b thresh %0d size %0d",
                         n, thresh_irq, rx_thresh, mq.size()); end
            checks++; if (rx_timeout !== e_to) begin errors++;
                $display("FAIL rnd_timeout@%0d: got %b want %b", n, rx_timeout, e_to); end
        end
        clr_in();
        uart_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_overrun();
        test_full_push_pop();
        test_thresh();
        test_timeout();
        test_uart_disable();
        test_flush();
        test_set_wins();
        test_midstream_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
